// File: rtl/spike_dispatcher_if.sv
// Source-address broadcast bus: the dispatcher drives the address and valid,
// the consuming side (neuron MAC decode) returns ready.
interface spike_dispatcher_if;
  logic [11:0] source_address;
  logic        source_valid;
  logic        source_ready;

  modport master (
    output source_address,
    output source_valid,
    input  source_ready
  );

  modport slave (
    input  source_address,
    input  source_valid,
    output source_ready
  );
endinterface

// File: rtl/spike_dispatcher.sv
// Timestep spike dispatcher: captures a cluster's spike vector on start and
// serialises it, lowest neuron index first, as source addresses on a
// valid/ready broadcast bus. The sentinel address is driven whenever no
// event is valid so downstream decoders never double-accumulate.
module spike_dispatcher #(
  parameter int          NUM_NEURONS  = 8,
  parameter logic [11:0] BASE_ADDRESS = 12'h000,
  parameter logic [11:0] IDLE_ADDRESS = 12'hFFF
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   start,
  spike_dispatcher_if.master     src,
  output logic                   busy,
  output logic                   done,
  output logic [6:0]             spike_count,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_r;
  state_e                 state_next_s;
  logic [NUM_NEURONS-1:0] pending_r;
  logic [NUM_NEURONS-1:0] pending_d_s;
  logic [NUM_NEURONS-1:0] pending_rest_s;
  logic [11:0]            addr_r;
  logic [11:0]            addr_d_s;
  logic                   valid_r;
  logic                   valid_d_s;
  logic                   busy_r;
  logic                   busy_d_s;
  logic                   done_r;
  logic                   done_d_s;
  logic [6:0]             count_r;
  logic [6:0]             count_d_s;
  logic                   overrun_r;
  logic                   overrun_d_s;
  logic                   accept_s;

  // Index of the lowest set bit, as a 12-bit offset from BASE_ADDRESS.
  function automatic logic [11:0] lowest_offset(input logic [NUM_NEURONS-1:0] v);
    logic [11:0] idx;
    idx = 12'h000;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      idx = v[i] ? 12'(i) : idx;
    end
    return idx;
  endfunction

  assign accept_s       = valid_r && src.source_ready;
  // Pending vector with its lowest set bit (the event on the bus) removed.
  assign pending_rest_s = pending_r & (pending_r - NUM_NEURONS'(1));

  // State and registered-output update; reset aborts any dispatch at once.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r   <= IDLE;
      pending_r <= '0;
      addr_r    <= IDLE_ADDRESS;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      count_r   <= 7'd0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_d_s;
      addr_r    <= addr_d_s;
      valid_r   <= valid_d_s;
      busy_r    <= busy_d_s;
      done_r    <= done_d_s;
      count_r   <= count_d_s;
      overrun_r <= overrun_d_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (spike_in != '0) ? SEND : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (accept_s && (pending_rest_s == '0)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SEND;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    pending_d_s = pending_r;
    count_d_s   = count_r;
    addr_d_s    = IDLE_ADDRESS;
    valid_d_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          pending_d_s = spike_in;
          count_d_s   = 7'd0;
        end else begin
          pending_d_s = pending_r;
        end
      end
      SEND: begin
        if (accept_s) begin
          pending_d_s = pending_rest_s;
          count_d_s   = count_r + 7'd1;
        end else begin
          pending_d_s = pending_r;
        end
      end
      DONE:    pending_d_s = pending_r;
      default: pending_d_s = '0;
    endcase
    // A held event keeps the same pending vector, hence the same address.
    if (state_next_s == SEND) begin
      valid_d_s = 1'b1;
      addr_d_s  = BASE_ADDRESS + lowest_offset(pending_d_s);
    end else begin
      valid_d_s = 1'b0;
      addr_d_s  = IDLE_ADDRESS;
    end
    overrun_d_s = overrun_r | (start && (state_r != IDLE));
    busy_d_s    = (state_next_s != IDLE);
    done_d_s    = (state_next_s == DONE);
  end

  assign src.source_address = addr_r;
  assign src.source_valid   = valid_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign spike_count        = count_r;
  assign overrun            = overrun_r;

endmodule

// File: doc/spike_dispatcher.md
# spike_dispatcher

Timestep-level spike event transmitter for the accelerator array. It latches the spike outputs of a cluster of neurons at the end of a timestep and serialises them, one per cycle, as 12-bit source addresses on the same `source_address` bus that neurons' MAC units decode. Between events it drives a sentinel address so that no neuron accumulates a weight twice. It sits between the neuron cluster's `spike` outputs and the shared source-address broadcast bus.

## Interface
- `NUM_NEURONS`, default 8: number of neurons whose spikes are collected (1..64).
- `BASE_ADDRESS`, default 12'h000: address of neuron index 0; neuron i is sent as `BASE_ADDRESS + i`.
- `IDLE_ADDRESS`, default 12'hFFF: sentinel driven when no event is valid; never used as a neuron address.

- `CLK`  in  1  system clock, rising edge.
- `RESETN`  in  1  asynchronous, active-low reset.
- `spike_in`  in  NUM_NEURONS  spike outputs of the neuron cluster, bit i = neuron i.
- `start`  in  1  one-cycle pulse at timestep end: capture `spike_in` and begin dispatch.
- `source_ready`  in  1  downstream accepts the current event this cycle.
- `source_address`  out  12  event address; `IDLE_ADDRESS` when `source_valid`=0.
- `source_valid`  out  1  `source_address` carries a spike event.
- `busy`  out  1  dispatch in progress (state != IDLE).
- `done`  out  1  one-cycle pulse when all captured spikes have been sent.
- `spike_count`  out  7  number of events accepted in the current/last dispatch.
- `overrun`  out  1  sticky: `start` arrived while busy.

## Operation
- States: IDLE, SEND, DONE.
- IDLE: `source_valid`=0, `source_address`=`IDLE_ADDRESS`. On `start`: `pending` <= `spike_in`, `spike_count` <= 0. Next state is SEND if `spike_in` != 0, otherwise DONE.
- SEND:
  - Priority-encode the lowest set bit k of `pending`.
  - Drive `source_address` = `BASE_ADDRESS + k` (mod 2^12) and `source_valid`=1.
  - On `source_valid && source_ready`: clear bit k and increment `spike_count`.
  - When the accepted bit was the last set bit, go to DONE.
  - With `source_ready`=0: address, valid and `pending` hold unchanged.
- DONE: `done`=1 for exactly one cycle with `source_valid`=0, then go to IDLE.
- Events are always sent in ascending neuron index. Each captured spike is accepted exactly once.
- `start` while SEND or DONE: ignored (`pending` is not modified) and `overrun` <= 1. `overrun` is cleared only by reset.
- `spike_in` changing after capture has no effect on the current dispatch.
- Address arithmetic is 12-bit unsigned with wrap. Integration must guarantee that no computed address equals `IDLE_ADDRESS`; the block does not check this.

## Timing
- All outputs are registered. Reset values:
  - `source_address`=`IDLE_ADDRESS`
  - `source_valid`=0, `busy`=0, `done`=0, `overrun`=0
  - `spike_count`=0
  - state=IDLE, `pending`=0
- `start` sampled in cycle T: first event is valid in T+1.
- With `source_ready` held at 1, N spikes occupy cycles T+1..T+N and `done` pulses in T+N+1. With zero spikes, `done` pulses in T+1.
- `busy` is 1 from T+1 through the `done` cycle inclusive.
- A new `start` is legal in the cycle after `done`, which is when state is IDLE.
- Handshake: valid/ready. `source_valid` never drops without acceptance, and the address is stable while valid && !ready.
- `RESETN` asserted mid-dispatch aborts immediately: unsent spikes are discarded and outputs return to reset values asynchronously.
- The downstream timestep `clear` to neurons is issued by the controller after `done`, not by this block.

## Test plan
- Reset: with `RESETN`=0, and after release, check `source_address`=12'hFFF, `source_valid`=0, `busy`=0, `spike_count`=0.
- Ordering: `spike_in`=8'b1010_0101, `BASE_ADDRESS`=12'h010, `source_ready`=1, `start` at T -> addresses 0x010, 0x012, 0x015, 0x017 in T+1..T+4, `done` at T+5, `spike_count`=4.
- Backpressure: `spike_in`=8'b0000_0011, `source_ready`=0 for cycles T+1..T+3 -> 0x000 held valid for 3 cycles, then 0x001 at T+5 with ready=1, `done` at T+6.
- Empty timestep: `spike_in`=0, `start` -> no valid cycle, `done` at T+1, `spike_count`=0, `busy`=1 only in T+1.
- Overrun: a second `start` at T+2 of a 4-spike dispatch -> `overrun`=1 and sticky; the event sequence and count are unchanged.
- Abort: `RESETN` pulsed low at T+2 of an 8-spike dispatch -> outputs reset immediately, `done` never pulses, and the next `start` dispatches normally.
